// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   state_e           : controller FSM states (RUN, MDU_LAUNCH, MDU_WAIT)
//   MduTimeoutDefault : default MDU_WAIT budget before a forced abort
//   NopInstr          : instruction word the flushed pipeline registers load (addi x0,x0,0)
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StMduLaunch = 2'd1,
    StMduWait   = 2'd2
  } state_e;

  localparam int unsigned MduTimeoutDefault = 64;

  localparam logic [31:0] NopInstr = 32'h0000_0013;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/enable bundle between the hazard/MDU logic and the stall controller.
//   Requests  : load_use_stall, ex_is_mdu, mdu_done, ex_branch_taken
//   Enables   : pc_we, pc_sel_target, if_id_we, id_ex_we
//   Flushes   : if_id_flush, id_ex_flush, ex_mem_flush
//   MDU ctrl  : mdu_start, mdu_busy, mdu_err
// Modports: master = the stall controller, slave = the pipeline/MDU side.
interface pipe_stall_ctrl_if;

  logic load_use_stall;
  logic ex_is_mdu;
  logic mdu_done;
  logic ex_branch_taken;

  logic pc_we;
  logic pc_sel_target;
  logic if_id_we;
  logic if_id_flush;
  logic id_ex_we;
  logic id_ex_flush;
  logic ex_mem_flush;
  logic mdu_start;
  logic mdu_busy;
  logic mdu_err;

  modport master (
    input  load_use_stall, ex_is_mdu, mdu_done, ex_branch_taken,
    output pc_we, pc_sel_target, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
    output ex_mem_flush, mdu_start, mdu_busy, mdu_err
  );

  modport slave (
    output load_use_stall, ex_is_mdu, mdu_done, ex_branch_taken,
    input  pc_we, pc_sel_target, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
    input  ex_mem_flush, mdu_start, mdu_busy, mdu_err
  );

endinterface

// File: rtl/pipe_stall_ctrl_perf_sat_counter.sv
// perf_sat_counter: Width-bit event counter that saturates at all-ones.
// Only built when PERF_CNT_EN is defined (its sole user is the PERF_CNT_EN block).
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears count to 0
//   en    : count this cycle
//   count : current value
`ifdef PERF_CNT_EN
module perf_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: turns hazard, MUL/DIV and branch-redirect requests into the PC and
// pipeline-register enables/flushes of the 5-stage core, and sequences the MDU handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (master) : requests in, enables/flushes/MDU control out (see pipe_stall_ctrl_if)
//   stall_cycles : cycles with pc_we low (PERF_CNT_EN only)
//   flush_events : branch redirects taken (PERF_CNT_EN only)
// Optional feature macro: PERF_CNT_EN (saturating performance counters).
// Outputs are combinational from state and inputs; while rst_n is low they are forced
// to the safe values (all enables low, all flushes high).
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MDU_TIMEOUT = MduTimeoutDefault,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_stall_ctrl_if.master   bus
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]    flush_events
`endif
);

  // Elaboration-time guard on the configuration.
  if (MDU_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_cfg
    $error("pipe_stall_ctrl: MDU_TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  localparam int unsigned WaitW = $clog2(MDU_TIMEOUT);
  typedef logic [WaitW-1:0] wait_cnt_t;
  localparam wait_cnt_t WaitLast = wait_cnt_t'(MDU_TIMEOUT - 1);

  state_e    state_q, state_d;
  wait_cnt_t wait_cnt_q, wait_cnt_d;
  logic      err_q, err_set;

  // Unmasked outputs of the FSM, before the reset override.
  logic pc_we_raw, pc_sel_raw, if_id_we_raw, if_id_flush_raw;
  logic id_ex_we_raw, id_ex_flush_raw, ex_mem_flush_raw;
  logic mdu_start_raw, mdu_busy_raw, redirect_raw;
  logic freeze;

  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    err_set          = 1'b0;
    freeze           = 1'b0;
    pc_we_raw        = 1'b1;
    pc_sel_raw       = 1'b0;
    if_id_we_raw     = 1'b1;
    if_id_flush_raw  = 1'b0;
    id_ex_we_raw     = 1'b1;
    id_ex_flush_raw  = 1'b0;
    ex_mem_flush_raw = 1'b0;
    mdu_start_raw    = 1'b0;
    mdu_busy_raw     = 1'b0;
    redirect_raw     = 1'b0;

    unique case (state_q)
      StRun: begin
        if (bus.ex_branch_taken) begin
          // Redirect: kill the two younger instructions in IF/ID and ID/EX.
          pc_sel_raw      = 1'b1;
          if_id_flush_raw = 1'b1;
          id_ex_flush_raw = 1'b1;
          redirect_raw    = 1'b1;
        end else if (bus.ex_is_mdu) begin
          freeze  = 1'b1;
          state_d = StMduLaunch;
        end else if (bus.load_use_stall) begin
          // Hold IF and ID, insert a bubble into EX; the hazard clears on its own.
          pc_we_raw       = 1'b0;
          if_id_we_raw    = 1'b0;
          id_ex_flush_raw = 1'b1;
        end
      end

      StMduLaunch: begin
        freeze        = 1'b1;
        mdu_start_raw = 1'b1;
        wait_cnt_d    = '0;
        state_d       = StMduWait;
      end

      StMduWait: begin
        mdu_busy_raw = 1'b1;
        wait_cnt_d   = wait_cnt_q + wait_cnt_t'(1);
        if (bus.mdu_done) begin
          // Release: ex_mem_flush stays low so the MDU result enters EX/MEM.
          state_d = StRun;
        end else if (wait_cnt_q == WaitLast) begin
          err_set = 1'b1;
          state_d = StRun;
        end else begin
          freeze = 1'b1;
        end
      end

      default: begin
        state_d = StRun;
      end
    endcase

    if (freeze) begin
      pc_we_raw        = 1'b0;
      if_id_we_raw     = 1'b0;
      id_ex_we_raw     = 1'b0;
      ex_mem_flush_raw = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_q | err_set;
    end
  end

  // Reset override: the pipeline must not advance while the core is held in reset.
  always_comb begin
    bus.pc_we         = rst_n & pc_we_raw;
    bus.pc_sel_target = rst_n & pc_sel_raw;
    bus.if_id_we      = rst_n & if_id_we_raw;
    bus.if_id_flush   = ~rst_n | if_id_flush_raw;
    bus.id_ex_we      = rst_n & id_ex_we_raw;
    bus.id_ex_flush   = ~rst_n | id_ex_flush_raw;
    bus.ex_mem_flush  = ~rst_n | ex_mem_flush_raw;
    bus.mdu_start     = rst_n & mdu_start_raw;
    bus.mdu_busy      = rst_n & mdu_busy_raw;
    bus.mdu_err       = err_q;
  end

`ifdef PERF_CNT_EN
  logic stall_en, flush_en;

  assign stall_en = rst_n & ~pc_we_raw;
  assign flush_en = rst_n & redirect_raw;

  perf_sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_en),
    .count (stall_cycles)
  );

  perf_sat_counter #(
    .Width (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_en),
    .count (flush_events)
  );
`endif

endmodule
